// File: rtl/stopwatch_ctrl.sv
// Purpose: stopwatch control FSM with button conditioning (2-flop sync + debounce) and tick prescaler.
// Latency: raw button edge to state change is DB_CYCLES+3 clk cycles; outputs are registered or decoded from registers.
// Backpressure: none; the counter strobes are fire-and-forget and button events never queue.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 500000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_start,
  input  logic       pb_lap,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_sel,
  output logic       run_led,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t st;

  // bit 0 = start/stop button, bit 1 = lap/clear button; all levels active-low
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         db_lvl;
  logic [1:0]         db_prev;
  logic [1:0][DW-1:0] db_cnt;
  logic [1:0]         press;
  logic               start_evt;
  logic               lap_evt;
  logic [PW-1:0]      presc;
  logic               tick;

  assign raw       = {pb_lap, pb_start};
  // a press is the debounced level falling; releases are deliberately silent
  assign press     = db_prev & ~db_lvl;
  assign start_evt = press[0];
  assign lap_evt   = press[1];
  assign tick      = (presc == P_LAST);
  // run_led is high exactly in RUN and LAP, so it doubles as the counting qualifier
  assign cnt_en    = tick & run_led;
  assign state     = st;

  // Synchronize both buttons, then accept a new level only after DB_CYCLES stable samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '1;
      sync2   <= '1;
      db_lvl  <= '1;
      db_prev <= '1;
      db_cnt  <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == D_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Prescaler: counts while time advances, freezes in PAUSE to keep the fractional tick, clears in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else begin
      case (st)
        IDLE:    presc <= '0;
        PAUSE:   presc <= presc;
        default: presc <= tick ? '0 : presc + PW'(1);
      endcase
    end
  end

  // Control FSM; outputs are registered alongside the state they decode (start beats lap)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      lap_load <= 1'b0;
      disp_sel <= 1'b0;
      run_led  <= 1'b0;
      cnt_clr  <= 1'b1;
    end else begin
      lap_load <= 1'b0;
      case (st)
        IDLE: begin
          if (start_evt) begin
            st      <= RUN;
            run_led <= 1'b1;
            cnt_clr <= 1'b0;
          end
        end
        RUN: begin
          if (start_evt) begin
            st      <= PAUSE;
            run_led <= 1'b0;
          end else if (lap_evt) begin
            st       <= LAP;
            lap_load <= 1'b1;
            disp_sel <= 1'b1;
          end
        end
        LAP: begin
          if (start_evt) begin
            st       <= PAUSE;
            run_led  <= 1'b0;
            disp_sel <= 1'b0;
          end else if (lap_evt) begin
            st       <= RUN;
            disp_sel <= 1'b0;
          end
        end
        PAUSE: begin
          if (start_evt) begin
            st      <= RUN;
            run_led <= 1'b1;
          end else if (lap_evt) begin
            st      <= IDLE;
            cnt_clr <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3.
// Expected outputs are queued per cycle while stimulus is driven and checked on the falling edge.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  // output vector layout: {state[1:0], cnt_en, cnt_clr, lap_load, disp_sel, run_led}
  localparam logic [6:0] M_ALL = 7'b1111111;
  localparam logic [6:0] M_ST  = 7'b1100000;
  localparam logic [6:0] M_CE  = 7'b0010000;
  localparam logic [6:0] M_CC  = 7'b0001000;
  localparam logic [6:0] M_LL  = 7'b0000100;
  localparam logic [6:0] M_DS  = 7'b0000010;
  localparam logic [6:0] M_RL  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pb_start = 1'b1;
  logic       pb_lap = 1'b1;
  logic       cnt_en, cnt_clr, lap_load, disp_sel, run_led;
  logic [1:0] state;
  logic [6:0] outs;

  stopwatch_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .pb_start (pb_start),
    .pb_lap   (pb_lap),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .lap_load (lap_load),
    .disp_sel (disp_sel),
    .run_led  (run_led),
    .state    (state)
  );

  assign outs = {state, cnt_en, cnt_clr, lap_load, disp_sel, run_led};

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] e;
    logic [6:0] m;
  } chk_t;

  chk_t       sb[$];
  int         nvec = 0;
  int         nmis = 0;
  int         cyc = 0;
  int         last_press = 0;
  bit         ev_s[0:1023];
  bit         ev_l[0:1023];

  // reference model state for the current cycle
  logic [1:0] m_st = S_IDLE;
  int         m_pre = 0;
  bit         m_ll = 1'b0;

  function automatic logic [6:0] ov(logic [1:0] s, bit ce, bit cc, bit ll, bit ds, bit rl);
    return {s, ce, cc, ll, ds, rl};
  endfunction

  task automatic expect_at(input int c, input string tag, input logic [6:0] e, input logic [6:0] m);
    chk_t x;
    x.cyc = c; x.tag = tag; x.e = e; x.m = m;
    sb.push_back(x);
  endtask

  // Advance the model across one clock edge, then queue its full expectation for the new cycle.
  task automatic step();
    logic [1:0] ns;
    bit         run;
    ns = m_st;
    if (rst) begin
      m_ll = 1'b0;
      if (ev_s[cyc]) begin
        case (m_st)
          S_IDLE:  ns = S_RUN;
          S_RUN:   ns = S_PAUSE;
          S_LAP:   ns = S_PAUSE;
          default: ns = S_RUN;
        endcase
      end else if (ev_l[cyc]) begin
        case (m_st)
          S_RUN:   begin ns = S_LAP; m_ll = 1'b1; end
          S_LAP:   ns = S_RUN;
          S_PAUSE: ns = S_IDLE;
          default: ns = S_IDLE;
        endcase
      end
      if (m_st == S_IDLE)       m_pre = 0;
      else if (m_st != S_PAUSE) m_pre = (m_pre + 1) % 4;
      m_st = ns;
    end
    @(posedge clk);
    #1;
    cyc++;
    run = (m_st == S_RUN) || (m_st == S_LAP);
    expect_at(cyc, "model", ov(m_st, (m_pre == 3) && run, m_st == S_IDLE, m_ll, m_st == S_LAP, run), M_ALL);
  endtask

  task automatic press(input bit s, input bit l, input int hold);
    if (s) begin pb_start = 1'b0; ev_s[cyc + 5] = 1'b1; end
    if (l) begin pb_lap = 1'b0; ev_l[cyc + 5] = 1'b1; end
    last_press = cyc;
    repeat (hold) step();
    pb_start = 1'b1;
    pb_lap   = 1'b1;
    repeat (8) step();
  endtask

  // Compare every expectation that falls due in this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        nvec++;
        assert ((outs & sb[i].m) === (sb[i].e & sb[i].m))
        else begin
          nmis++;
          $error("FAIL %s cyc=%0d observed=%b expected=%b mask=%b", sb[i].tag, cyc, outs, sb[i].e, sb[i].m);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int n;

    // reset held for a few cycles, then released
    repeat (3) step();
    rst = 1'b1;
    repeat (4) step();

    // clean start press: RUN exactly 6 cycles after the raw edge, first cnt_en 3 cycles later
    n = cyc;
    expect_at(n + 5, "pre_run_idle", ov(S_IDLE, 0, 1, 0, 0, 0), M_ALL);
    expect_at(n + 6, "run_entry",    ov(S_RUN,  0, 0, 0, 0, 1), M_ALL);
    expect_at(n + 9, "first_cnt_en", ov(S_RUN,  1, 0, 0, 0, 1), M_ALL);
    press(1'b1, 1'b0, 4);
    repeat (6) step();

    // bounce on start (low 2, high 1, low 2) must produce no event
    pb_start = 1'b0; repeat (2) step();
    pb_start = 1'b1; step();
    pb_start = 1'b0; repeat (2) step();
    pb_start = 1'b1; repeat (8) step();
    expect_at(cyc, "bounce_ignored", ov(S_RUN, 0, 0, 0, 0, 1), M_ST | M_RL);
    step();

    // long hold gives a single transition to PAUSE, then resume
    press(1'b1, 1'b0, 12);
    press(1'b1, 1'b0, 4);

    // lap: lap_load one cycle, display switches, counting continues
    n = cyc;
    expect_at(n + 6, "lap_entry", ov(S_LAP, 0, 0, 1, 1, 1), M_ST | M_LL | M_DS | M_RL);
    expect_at(n + 7, "lap_load_once", ov(S_LAP, 0, 0, 0, 1, 1), M_ST | M_LL | M_DS);
    press(1'b0, 1'b1, 4);
    repeat (6) step();
    n = cyc;
    expect_at(n + 6, "lap_exit", ov(S_RUN, 0, 0, 0, 0, 1), M_ST | M_DS | M_RL);
    press(1'b0, 1'b1, 4);

    // pause with prescaler held at 2, resume gives cnt_en one cycle later
    while (m_pre != 0) step();
    n = cyc;
    expect_at(n + 6, "pause_entry", ov(S_PAUSE, 0, 0, 0, 0, 0), M_ST | M_CE | M_RL);
    press(1'b1, 1'b0, 4);
    repeat (5) step();
    n = cyc;
    expect_at(n + 6, "resume_no_tick", ov(S_RUN, 0, 0, 0, 0, 1), M_ST | M_CE);
    expect_at(n + 7, "resume_tick",    ov(S_RUN, 1, 0, 0, 0, 1), M_ST | M_CE);
    press(1'b1, 1'b0, 4);

    // pause then lap clears back to IDLE
    press(1'b1, 1'b0, 4);
    n = cyc;
    expect_at(n + 6, "clear_idle", ov(S_IDLE, 0, 1, 0, 0, 0), M_ALL);
    press(1'b0, 1'b1, 4);
    press(1'b0, 1'b1, 4);   // lap in IDLE is ignored
    press(1'b1, 1'b0, 4);   // restart; prescaler starts from 0

    // simultaneous start+lap in RUN: start wins, no lap_load
    n = cyc;
    expect_at(n + 6, "both_pause", ov(S_PAUSE, 0, 0, 0, 0, 0), M_ST | M_LL | M_DS | M_RL);
    press(1'b1, 1'b1, 4);
    press(1'b1, 1'b0, 4);
    press(1'b0, 1'b1, 4);
    repeat (3) step();

    // asynchronous reset mid-LAP with start held low through release
    pb_start = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    nvec++;
    assert (outs === ov(S_IDLE, 0, 1, 0, 0, 0))
    else begin
      nmis++;
      $error("FAIL async_reset observed=%b expected=%b", outs, ov(S_IDLE, 0, 1, 0, 0, 0));
    end
    m_st = S_IDLE; m_pre = 0; m_ll = 1'b0;
    for (int i = 0; i < 1024; i++) begin ev_s[i] = 1'b0; ev_l[i] = 1'b0; end
    repeat (3) step();
    rst = 1'b1;
    n = cyc;
    ev_s[n + 5] = 1'b1;
    expect_at(n + 5, "held_no_early_event", ov(S_IDLE, 0, 1, 0, 0, 0), M_ALL);
    expect_at(n + 6, "held_event_after_db", ov(S_RUN,  0, 0, 0, 0, 1), M_ALL);
    repeat (4) step();
    pb_start = 1'b1;
    repeat (10) step();

    @(negedge clk);
    #2;
    nvec++;
    assert (sb.size() == 0)
    else begin
      nmis++;
      $error("FAIL unchecked_entries observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
